// File: rtl/biu_fifo_nimo.sv
// Multi-input, multi-output FIFO: sparse write lanes are packed into consecutive
// slots, and the oldest NO entries are presented fall-through and retired in order.
module biu_fifo_nimo #(
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int NI    = 2,
  parameter int NO    = 1,
  parameter int AF_TH = (1 << AW) - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [NI-1:0]    din_valid,
  input  logic [NI*DW-1:0] din,
  output logic             allowIn,
  input  logic [NO-1:0]    pop,
  output logic [NO-1:0]    dout_valid,
  output logic [NO*DW-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             almost_full
);

  localparam int DEPTH = 1 << AW;
  localparam int NVW   = $clog2(NI + 1);
  localparam int NPW   = $clog2(NO + 1);

  logic [DW-1:0]  mem [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;

  logic [NVW-1:0] nv;
  logic [NPW-1:0] np;
  logic [AW-1:0]  lane_off [NI];
  logic [AW:0]    space;
  logic           push;

  // Population count of the write lanes plus each lane's packed slot offset.
  always_comb begin
    logic [AW-1:0] run;
    nv  = '0;
    run = '0;
    for (int k = 0; k < NI; k++) begin
      lane_off[k] = run;
      run         = run + AW'(din_valid[k]);
      nv          = nv + NVW'(din_valid[k]);
    end
  end

  // Admission uses only the registered count, so a same-cycle pop never makes room.
  always_comb begin
    space   = (AW + 1)'(DEPTH) - count_q;
    allowIn = !flush && (space >= (AW + 1)'(nv));
    push    = allowIn && (nv != '0);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NO; gi++) begin : g_rd
      assign dout_valid[gi]        = count_q > (AW + 1)'(gi);
      assign dout[gi*DW +: DW]     = mem[rd_ptr_q + AW'(gi)];
    end
  endgenerate

  // Retire only the unbroken run of requested, valid lanes starting at lane 0.
  always_comb begin
    logic run;
    np  = '0;
    run = 1'b1;
    for (int j = 0; j < NO; j++) begin
      run = run & pop[j] & dout_valid[j];
      np  = np + NPW'(run);
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(np);
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(nv);
      end
      count_d = count_q + (push ? (AW + 1)'(nv) : '0) - (AW + 1)'(np);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < NI; k++) begin
        if (din_valid[k]) begin
          mem[wr_ptr_q + lane_off[k]] <= din[k*DW +: DW];
        end
      end
    end
  end

  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == (AW + 1)'(DEPTH));
  assign almost_full = (count_q >= (AW + 1)'(AF_TH));

endmodule

// File: tb/tb_biu_fifo_nimo.sv
// Directed bench for biu_fifo_nimo at AW=2, DW=8, NI=3, NO=2, AF_TH=3:
// a vector table of per-cycle stimulus/expectations plus reset sequences.
module tb_biu_fifo_nimo;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int NI = 3;
  localparam int NO = 2;
  localparam int AF = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [NI-1:0]    din_valid;
  logic [NI*DW-1:0] din;
  logic             allowIn;
  logic [NO-1:0]    pop;
  logic [NO-1:0]    dout_valid;
  logic [NO*DW-1:0] dout;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             almost_full;

  int n_cmp = 0;
  int n_err = 0;

  biu_fifo_nimo #(.AW(AW), .DW(DW), .NI(NI), .NO(NO), .AF_TH(AF)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .din_valid   (din_valid),
    .din         (din),
    .allowIn     (allowIn),
    .pop         (pop),
    .dout_valid  (dout_valid),
    .dout        (dout),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  vin;
    logic [23:0] din;
    logic [1:0]  pop;
    logic        fl;
    logic        e_allow;
    logic [2:0]  e_count;
    logic [1:0]  e_dv;
    logic [15:0] e_dout;
  } vec_t;

  vec_t vec [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input int idx, input logic [2:0] ec, input logic [1:0] ev,
                           input logic [15:0] ed);
    chk($sformatf("v%0d count", idx), 32'(count), 32'(ec));
    chk($sformatf("v%0d dout_valid", idx), 32'(dout_valid), 32'(ev));
    chk($sformatf("v%0d empty", idx), 32'(empty), 32'(ec == 3'd0));
    chk($sformatf("v%0d full", idx), 32'(full), 32'(ec == 3'd4));
    chk($sformatf("v%0d almost_full", idx), 32'(almost_full), 32'(ec >= 3'd3));
    if (ev[0]) chk($sformatf("v%0d dout0", idx), 32'(dout[7:0]), 32'(ed[7:0]));
    if (ev[1]) chk($sformatf("v%0d dout1", idx), 32'(dout[15:8]), 32'(ed[15:8]));
  endtask

  initial begin
    vec[0]  = '{3'b101, 24'hC3B2A1, 2'b00, 1'b0, 1'b1, 3'd2, 2'b11, 16'hC3A1};
    vec[1]  = '{3'b111, 24'h112233, 2'b11, 1'b0, 1'b0, 3'd0, 2'b00, 16'h0000};
    vec[2]  = '{3'b010, 24'h00D400, 2'b00, 1'b0, 1'b1, 3'd1, 2'b01, 16'h00D4};
    vec[3]  = '{3'b000, 24'h000000, 2'b11, 1'b0, 1'b1, 3'd0, 2'b00, 16'h0000};
    vec[4]  = '{3'b011, 24'h00E6E5, 2'b00, 1'b0, 1'b1, 3'd2, 2'b11, 16'hE6E5};
    vec[5]  = '{3'b000, 24'h000000, 2'b10, 1'b0, 1'b1, 3'd2, 2'b11, 16'hE6E5};
    vec[6]  = '{3'b001, 24'h0000F7, 2'b01, 1'b0, 1'b1, 3'd2, 2'b11, 16'hF7E6};
    vec[7]  = '{3'b111, 24'h999897, 2'b11, 1'b1, 1'b0, 3'd0, 2'b00, 16'h0000};
    vec[8]  = '{3'b111, 24'h121110, 2'b00, 1'b0, 1'b1, 3'd3, 2'b11, 16'h1110};
    vec[9]  = '{3'b000, 24'h000000, 2'b11, 1'b0, 1'b1, 3'd1, 2'b01, 16'h0012};
    vec[10] = '{3'b111, 24'h151413, 2'b00, 1'b0, 1'b1, 3'd4, 2'b11, 16'h1312};
    vec[11] = '{3'b000, 24'h000000, 2'b00, 1'b0, 1'b1, 3'd4, 2'b11, 16'h1312};
    vec[12] = '{3'b001, 24'h0000AA, 2'b11, 1'b0, 1'b0, 3'd2, 2'b11, 16'h1514};
    vec[13] = '{3'b000, 24'h000000, 2'b11, 1'b0, 1'b1, 3'd0, 2'b00, 16'h0000};
    vec[14] = '{3'b111, 24'h232221, 2'b00, 1'b0, 1'b1, 3'd3, 2'b11, 16'h2221};
    vec[15] = '{3'b001, 24'h00005A, 2'b11, 1'b1, 1'b0, 3'd0, 2'b00, 16'h0000};
    vec[16] = '{3'b001, 24'h000031, 2'b00, 1'b0, 1'b1, 3'd1, 2'b01, 16'h0031};
    vec[17] = '{3'b001, 24'h000032, 2'b01, 1'b0, 1'b1, 3'd1, 2'b01, 16'h0032};

    rst       = 1'b1;
    flush     = 1'b0;
    din_valid = '0;
    din       = '0;
    pop       = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_state(-1, 3'd0, 2'b00, 16'h0000);
    din_valid = 3'b111;
    #1;
    chk("reset allowIn", 32'(allowIn), 32'd1);
    din_valid = 3'b000;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      din_valid = vec[i].vin;
      din       = vec[i].din;
      pop       = vec[i].pop;
      flush     = vec[i].fl;
      #1;
      chk($sformatf("v%0d allowIn", i), 32'(allowIn), 32'(vec[i].e_allow));
      @(posedge clk);
      #1;
      din_valid = '0;
      pop       = '0;
      flush     = 1'b0;
      chk_state(i, vec[i].e_count, vec[i].e_dv, vec[i].e_dout);
      $display("vec %0d: vin=%b pop=%b flush=%b -> count=%0d dv=%b dout=%h",
               i, vec[i].vin, vec[i].pop, vec[i].fl, count, dout_valid, dout);
    end

    // Asynchronous reset in the middle of a cycle with data held.
    @(negedge clk);
    din_valid = 3'b011;
    din       = 24'h007766;
    @(posedge clk);
    #1;
    din_valid = '0;
    chk("pre-rst count", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_state(100, 3'd0, 2'b00, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst count", 32'(count), 32'd0);
    $display("async reset mid-cycle: count=%0d empty=%b", count, empty);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/biu_fifo_nimo.md
Name: biu_fifo_nimo

Overview:
- Parametrised multi-input, multi-output FIFO for the BIU. Generalises the two-in/one-out buffer to NI write lanes and NO read lanes.
- Sparse valid write lanes are compacted, in lane order, into consecutive slots.
- Up to NO oldest entries are presented each cycle and retired as a thermometer-coded pop.
- Adds synchronous flush, occupancy count and a programmable almost-full flag. Sits between the response/fill merge logic and the BIU's downstream consumers.

Parameters:
- AW, 4: address width; DEPTH = 1<<AW entries.
- DW, 32: entry data width.
- NI, 2: write lanes. Legal range 1..DEPTH.
- NO, 1: read lanes. Legal range 1..DEPTH.
- AF_TH, DEPTH-2: almost_full asserts when count >= AF_TH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all contents.
- din_valid  in  NI  per-lane write valid; any bit pattern is legal.
- din  in  NI*DW  lane k occupies bits [k*DW +: DW].
- allowIn  out  1  the whole valid set is accepted this cycle.
- pop  in  NO  retire request, lane j = j-th oldest entry.
- dout_valid  out  NO  lane j holds valid data.
- dout  out  NO*DW  lane j = entry at rd_ptr+j.
- count  out  AW+1  current occupancy, registered.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_TH.

Behaviour:
- Reset (async): rd_ptr = 0, wr_ptr = 0, count = 0. Therefore empty = 1, full = 0, almost_full = (AF_TH == 0), dout_valid = 0. Memory is not reset.
- nv = popcount(din_valid), width clog2(NI+1).
- allowIn = !flush && (DEPTH - count >= nv). It depends on registered count only; a same-cycle pop never frees space for a push.
- Push happens when allowIn && nv != 0. It is all-or-nothing: there is no partial acceptance.
  - The i-th set bit of din_valid, counting from lane 0, writes mem[wr_ptr+i].
  - wr_ptr advances by nv. All pointer arithmetic is mod DEPTH; wrap is natural AW-bit overflow.
- dout_valid[j] = (count > j).
- dout lane j = mem[rd_ptr+j], combinational read, zero-latency (first-word fall-through). A pushed entry becomes visible the cycle after the write.
- Effective pops: np = number of leading ones of (pop & dout_valid), starting at lane 0.
  - Pop bits above the first zero are ignored. Example: pop = 2'b10 retires nothing.
  - Popping an invalid lane is ignored, never underflows.
  - rd_ptr advances by np.
- count_next = count + (push ? nv : 0) - np. It is updated every cycle; the invariant 0 <= count <= DEPTH holds by construction.
- Simultaneous push and pop: both take effect. Pop addresses come from the current rd_ptr; there is no read-after-write bypass within a cycle.
- Flush (synchronous, highest priority): next cycle rd_ptr = wr_ptr = count = 0. In the flush cycle allowIn = 0, and pushes and pops are dropped.
- Async reset mid-operation: state clears immediately. Contents are lost; outputs take their reset values while rst is high.
- Full: allowIn = 1 only when nv = 0.
- Empty: dout_valid = 0 and all pops are ignored.

Test Plan:
All scenarios use AW=2 (DEPTH=4), DW=8, NI=3, NO=2, AF_TH=3.
1. Reset release, idle -> count = 0, empty = 1, dout_valid = 2'b00, allowIn = 1 for din_valid = 3'b111.
2. Compaction: din_valid = 3'b101, din = {8'hC3, 8'hB2, 8'hA1} -> next cycle count = 2, dout = {8'hC3, 8'hA1}, dout_valid = 2'b11.
3. Overflow guard: count = 2, din_valid = 3'b111 -> allowIn = 0 and nothing is written, even with pop = 2'b11 in the same cycle. The pop still takes effect: count becomes 0.
4. Wrap: push 3 entries, pop 2, push 3 more (0x10..0x15 in order) -> reads return 0x12..0x15 in order across the pointer wrap. full = 1 and almost_full = 1 at count = 4.
5. Pop rules: count = 1, pop = 2'b11 -> count = 0. Then count = 2, pop = 2'b10 -> count stays 2.
6. Flush with concurrent push/pop at count = 3 -> next cycle count = 0, empty = 1. The dropped push does not appear on any later read.
